// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared types and constants for the PS/2 keyboard receiver
// Contents:
//   kbd_state_e       frame FSM states (IDLE, DATA, PARITY, STOP)
//   KBD_EXT_CODE      scan-code prefix that marks an extended key (8'hE0)
//   KBD_BRK_CODE      scan-code prefix that marks a key release (8'hF0)
//   KBD_BRK_BIT       key_data bit holding the break flag
//   KBD_EXT_BIT       key_data bit holding the extended flag
//   kbd_entry()       packs code and flags into a 16-bit key entry
package kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } kbd_state_e;

    localparam logic [7:0] KBD_EXT_CODE = 8'hE0;
    localparam logic [7:0] KBD_BRK_CODE = 8'hF0;

    localparam int KBD_BRK_BIT = 8;
    localparam int KBD_EXT_BIT = 9;

    function automatic logic [15:0] kbd_entry(input logic [7:0] code,
                                              input logic       ext,
                                              input logic       brk);
        logic [15:0] e;
        e              = 16'h0000;
        e[7:0]         = code;
        e[KBD_BRK_BIT] = brk;
        e[KBD_EXT_BIT] = ext;
        return e;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// rtl/kbd_fifo.sv - show-ahead key FIFO with count-based full/empty
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   push_i        write push_data_i at the tail (dropped when full and not popping)
//   push_data_i   entry to write
//   pop_i         remove the head entry (ignored when empty)
//   head_o        head entry, all zeros while empty
//   empty_o       FIFO holds no entries
//   drop_o        a push was refused because the FIFO was full
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             full, pop_ok, push_ok;

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == CNT_MAX);
    assign pop_ok  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push_i & (~full | pop_ok);
    assign drop_o  = push_i & full & ~pop_ok;
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_q <= rd_q + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd.sv
// rtl/ps2_kbd.sv - PS/2 keyboard frame receiver with prefix decoding and key FIFO
// Optional feature macro: KBD_PARITY_CHK_EN (drop frames with bad odd parity).
// Ports:
//   clk, rstn     system clock, asynchronous active-low reset
//   ps2_clk       PS/2 device clock (asynchronous)
//   ps2_data      PS/2 device data (asynchronous)
//   key_en        pop strobe for the head entry
//   key_data      head entry {6'b0, ext, brk, code}, zero while empty
//   key_av        FIFO non-empty
//   kbd_ovf       sticky overflow, cleared only by reset
module ps2_kbd
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        key_en,
    output logic [15:0] key_data,
    output logic        key_av,
    output logic        kbd_ovf
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    logic [1:0]  clk_sync_q, data_sync_q;
    logic        clk_prev_q;
    kbd_state_e  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        done_q, done_d;
    logic        ext_q, ext_d, brk_q, brk_d, ovf_q, ovf_d;
    logic        fall, sdata;
    logic        is_ext, is_brk, push, fifo_empty, fifo_drop;

    assign sdata = data_sync_q[1];
    assign fall  = clk_prev_q & ~clk_sync_q[1];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        tmo_d     = tmo_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (fall && !sdata) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d   = {sdata, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
`ifdef KBD_PARITY_CHK_EN
                    // Odd parity: data plus parity must hold an odd number of ones.
                    par_ok_d = ^{sdata, shift_q};
`else
                    par_ok_d = 1'b1;
`endif
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    done_d  = sdata & par_ok_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abandon a partial frame if the device stops clocking mid-frame.
        if (state_q != ST_IDLE) begin
            if (fall) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                state_d   = ST_IDLE;
                bit_cnt_d = 3'd0;
                tmo_d     = '0;
            end else begin
                tmo_d = tmo_q + TMO_ONE;
            end
        end
    end

    // The completed code stays in shift_q for the cycle after done_q rises,
    // since shifting only happens once a new start bit has been seen.
    always_comb begin
        is_ext = done_q && (shift_q == KBD_EXT_CODE);
        is_brk = done_q && (shift_q == KBD_BRK_CODE);
        push   = done_q && !is_ext && !is_brk;
        ext_d  = push ? 1'b0 : (ext_q | is_ext);
        brk_d  = push ? 1'b0 : (brk_q | is_brk);
        ovf_d  = ovf_q | fifo_drop;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_ok_q    <= 1'b1;
            tmo_q       <= '0;
            done_q      <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_prev_q  <= clk_sync_q[1];
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_ok_q    <= par_ok_d;
            tmo_q       <= tmo_d;
            done_q      <= done_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            ovf_q       <= ovf_d;
        end
    end

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (push),
        .push_data_i (kbd_entry(shift_q, ext_q, brk_q)),
        .pop_i       (key_en),
        .head_o      (key_data),
        .empty_o     (fifo_empty),
        .drop_o      (fifo_drop)
    );

    assign key_av  = ~fifo_empty;
    assign kbd_ovf = ovf_q;

endmodule

// File: tb/tb_ps2_kbd.sv
// tb/tb_ps2_kbd.sv - self-checking bench for ps2_kbd with a queue-based reference model
module tb_ps2_kbd;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        key_en = 1'b0;
    logic [15:0] key_data;
    logic        key_av;
    logic        kbd_ovf;

    always #5 clk = ~clk;

    ps2_kbd #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_en   (key_en),
        .key_data (key_data),
        .key_av   (key_av),
        .kbd_ovf  (kbd_ovf)
    );

    typedef struct {
        int          due;
        logic [15:0] val;
    } pend_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] mq[$];
    pend_t       pend[$];
    bit          m_ovf = 0, m_ext = 0, m_brk = 0;
    bit          popper_on = 0;

    // Reference model: entries become visible four clk edges after the
    // stop-bit falling edge (2 sync flops, edge detect, push).
    initial begin
        forever begin
            @(posedge clk);
            if (rstn) begin
                bit          do_pop, do_push;
                logic [15:0] v;
                cyc++;
                do_pop  = key_en && (mq.size() > 0);
                do_push = 0;
                v       = 16'h0;
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    do_push = 1;
                    v       = pend[0].val;
                    pend.delete(0);
                end
                if (do_pop) mq.delete(0);
                if (do_push) begin
                    if (mq.size() < DEPTH) mq.push_back(v);
                    else m_ovf = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                logic [15:0] ed;
                logic        ea;
                ea = (mq.size() != 0);
                ed = ea ? mq[0] : 16'h0000;
                checks += 3;
                if (key_av !== ea) begin
                    errors++;
                    $display("FAIL cyc_key_av cyc=%0d got=%b exp=%b", cyc, key_av, ea);
                end
                if (key_data !== ed) begin
                    errors++;
                    $display("FAIL cyc_key_data cyc=%0d got=%h exp=%h", cyc, key_data, ed);
                end
                if (kbd_ovf !== m_ovf) begin
                    errors++;
                    $display("FAIL cyc_kbd_ovf cyc=%0d got=%b exp=%b", cyc, kbd_ovf, m_ovf);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic model_frame(input logic [7:0] code, input logic par, input logic stop);
        bit valid;
`ifdef KBD_PARITY_CHK_EN
        valid = stop && (^{code, par});
`else
        valid = stop;
`endif
        if (valid) begin
            if (code == 8'hE0) m_ext = 1;
            else if (code == 8'hF0) m_brk = 1;
            else begin
                pend.push_back('{cyc + 4, {6'b0, m_ext, m_brk, code}});
                m_ext = 0;
                m_brk = 0;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] code, input logic par, input logic stop,
                              input bit pop_at_push, input int h);
        logic [10:0] bits;
        bits = {stop, par, code, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (h) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                model_frame(code, par, stop);
                if (pop_at_push) begin
                    repeat (3) @(negedge clk);
                    key_en = 1'b1;
                    @(negedge clk);
                    key_en = 1'b0;
                    repeat (h) @(negedge clk);
                end else begin
                    repeat (h) @(negedge clk);
                end
            end else begin
                repeat (h) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_code(input logic [7:0] code);
        send_frame(code, ~^code, 1'b1, 0, 5);
    endtask

    task automatic send_partial(input int nbits);
        for (int i = 0; i <= nbits; i++) begin
            @(negedge clk);
            ps2_data = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (5) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        key_en = 1'b1;
        @(negedge clk);
        key_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        key_en = 1'b0;
        mq.delete();
        pend.delete();
        m_ovf = 0;
        m_ext = 0;
        m_brk = 0;
        #1;
        check16("reset_key_av", {15'b0, key_av}, 16'h0);
        check16("reset_key_data", key_data, 16'h0000);
        check16("reset_kbd_ovf", {15'b0, kbd_ovf}, 16'h0);
        repeat (3) @(negedge clk);
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        do_reset();
        repeat (4) @(negedge clk);

        // Single make code
        send_code(8'h1C);
        check16("make_1c_data", key_data, 16'h001C);
        check16("make_1c_av", {15'b0, key_av}, 16'h1);
        pop();
        check16("pop_1c_av", {15'b0, key_av}, 16'h0);
        check16("pop_1c_data", key_data, 16'h0000);

        // Prefixes
        send_code(8'hE0);
        check16("prefix_e0_nopush", {15'b0, key_av}, 16'h0);
        send_code(8'hF0);
        check16("prefix_f0_nopush", {15'b0, key_av}, 16'h0);
        send_code(8'h75);
        check16("ext_brk_75", key_data, 16'h0375);
        pop();
        check16("ext_brk_single", {15'b0, key_av}, 16'h0);
        send_code(8'hF0);
        send_code(8'h1C);
        check16("brk_1c", key_data, 16'h011C);
        pop();

        // Overflow
        for (int i = 1; i <= 9; i++) send_code(8'(i));
        check16("ovf_set", {15'b0, kbd_ovf}, 16'h1);
        for (int i = 1; i <= 8; i++) begin
            check16("ovf_order", key_data, 16'(i));
            pop();
        end
        check16("ovf_drained", {15'b0, key_av}, 16'h0);

        // Full FIFO with coincident push and pop
        do_reset();
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 8; i++) send_code(8'(i));
        send_frame(8'h55, ~^8'h55, 1'b1, 1, 6);
        check16("full_pushpop_ovf", {15'b0, kbd_ovf}, 16'h0);
        for (int i = 2; i <= 8; i++) begin
            check16("full_pushpop_order", key_data, 16'(i));
            pop();
        end
        check16("full_pushpop_tail", key_data, 16'h0055);
        pop();
        check16("full_pushpop_empty", {15'b0, key_av}, 16'h0);

        // Timeout of a partial frame
        send_partial(4);
        repeat (TMO + 20) @(negedge clk);
        send_code(8'h2A);
        check16("timeout_2a", key_data, 16'h002A);
        pop();

        // Wrong parity
        send_frame(8'h1C, 1'b1, 1'b1, 0, 5);
`ifdef KBD_PARITY_CHK_EN
        check16("parity_bad_dropped", {15'b0, key_av}, 16'h0);
`else
        check16("parity_ignored", key_data, 16'h001C);
        pop();
`endif

        // Reset mid-frame
        send_partial(3);
        ps2_clk = 1'b0;
        do_reset();
        repeat (4) @(negedge clk);
        send_code(8'h33);
        check16("after_midreset", key_data, 16'h0033);
        pop();

        // Randomized traffic with background pops
        popper_on = 1;
        fork
            begin
                while (popper_on) begin
                    @(negedge clk);
                    key_en = ($urandom_range(0, 3) == 0);
                end
                key_en = 1'b0;
            end
        join_none
        for (int n = 0; n < 60; n++) begin
            int          r;
            logic [7:0]  code;
            logic        par, stop;
            r    = $urandom_range(0, 9);
            code = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
            stop = ($urandom_range(0, 9) != 0);
            par  = (~^code) ^ ($urandom_range(0, 6) == 0);
            send_frame(code, par, stop, 0, $urandom_range(3, 8));
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end
        popper_on = 0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < DEPTH + 2 && key_av; i++) pop();
        check16("final_drained", {15'b0, key_av}, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
